// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter that funnels CHANNELS read/write requesters onto one memory port,
// keeping at most one transaction outstanding and routing the response back to its owner.
module bus_arbiter_rr #(
    parameter int CHANNELS      = 2,
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [CHANNELS-1:0]                ch_req_valid,
    output logic [CHANNELS-1:0]                ch_req_ready,
    input  logic [CHANNELS-1:0]                ch_req_write,
    input  logic [CHANNELS*ADDRESS_WIDTH-1:0]  ch_req_address,
    input  logic [CHANNELS*DATA_WIDTH-1:0]     ch_req_wdata,
    input  logic [CHANNELS*DATA_WIDTH/8-1:0]   ch_req_byte_enable,
    output logic [CHANNELS-1:0]                ch_resp_valid,
    output logic [DATA_WIDTH-1:0]              ch_resp_rdata,
    output logic                               mem_valid,
    input  logic                               mem_ready,
    output logic                               mem_write,
    output logic [ADDRESS_WIDTH-1:0]           mem_address,
    output logic [DATA_WIDTH-1:0]              mem_wdata,
    output logic [DATA_WIDTH/8-1:0]            mem_byte_enable,
    input  logic                               mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]              mem_rdata
);

    localparam int GW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int BW = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        RESPOND = 2'd3
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [GW-1:0]   last_grant;
    logic [GW-1:0]   grant;
    logic [GW-1:0]   pick;
    logic            pick_found;
    logic            accept;
    logic            capture;

    // Search starts just past the previous winner so every channel gets its turn.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        for (int i = 1; i <= CHANNELS; i++) begin
            if (!pick_found && ch_req_valid[(int'(last_grant) + i) % CHANNELS]) begin
                pick       = GW'((int'(last_grant) + i) % CHANNELS);
                pick_found = 1'b1;
            end
        end
    end

    assign accept  = (state == IDLE) && pick_found && !reset;
    assign capture = ((state == ISSUE) && mem_ready && mem_resp_valid) ||
                     ((state == WAIT) && mem_resp_valid);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_ready) begin
                    state_next = mem_resp_valid ? RESPOND : WAIT;
                end
            end
            WAIT: begin
                if (mem_resp_valid) begin
                    state_next = RESPOND;
                end
            end
            RESPOND: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        ch_req_ready        = '0;
        ch_req_ready[pick]  = accept;
        ch_resp_valid       = '0;
        ch_resp_valid[grant] = (state == RESPOND);
        mem_valid           = (state == ISSUE);
    end

    // Request fields are latched at accept so requesters may drop them afterwards.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant      <= GW'(CHANNELS - 1);
            grant           <= '0;
            mem_write       <= 1'b0;
            mem_address     <= '0;
            mem_wdata       <= '0;
            mem_byte_enable <= '0;
            ch_resp_rdata   <= '0;
        end else begin
            if (accept) begin
                grant           <= pick;
                last_grant      <= pick;
                mem_write       <= ch_req_write[pick];
                mem_address     <= ch_req_address[int'(pick)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                mem_wdata       <= ch_req_wdata[int'(pick)*DATA_WIDTH +: DATA_WIDTH];
                mem_byte_enable <= ch_req_byte_enable[int'(pick)*BW +: BW];
            end
            if (capture) begin
                ch_resp_rdata <= mem_write ? '0 : mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench for bus_arbiter_rr: a 2-channel instance for the main scenarios
// and a 4-channel instance for pointer wrap and spurious-response handling.
module tb_bus_arbiter_rr;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // 2-channel instance
    logic [1:0]   req_valid = '0;
    logic [1:0]   req_ready;
    logic [1:0]   req_write = '0;
    logic [63:0]  req_address = '0;
    logic [63:0]  req_wdata = '0;
    logic [7:0]   req_be = '0;
    logic [1:0]   resp_valid;
    logic [31:0]  resp_rdata;
    logic         mem_valid;
    logic         mem_ready = 1'b0;
    logic         mem_write;
    logic [31:0]  mem_address;
    logic [31:0]  mem_wdata;
    logic [3:0]   mem_be;
    logic         mem_resp_valid = 1'b0;
    logic [31:0]  mem_rdata = '0;

    // 4-channel instance
    logic [3:0]   req_valid4 = '0;
    logic [3:0]   req_ready4;
    logic [3:0]   req_write4 = '0;
    logic [127:0] req_address4 = '0;
    logic [127:0] req_wdata4 = '0;
    logic [15:0]  req_be4 = '0;
    logic [3:0]   resp_valid4;
    logic [31:0]  resp_rdata4;
    logic         mem_valid4;
    logic         mem_ready4 = 1'b0;
    logic         mem_write4;
    logic [31:0]  mem_address4;
    logic [31:0]  mem_wdata4;
    logic [3:0]   mem_be4;
    logic         mem_resp_valid4 = 1'b0;
    logic [31:0]  mem_rdata4 = '0;

    int n_checks = 0;
    int n_pass   = 0;

    bus_arbiter_rr #(.CHANNELS(2), .ADDRESS_WIDTH(32), .DATA_WIDTH(32)) u_dut2 (
        .clock(clock), .reset(reset),
        .ch_req_valid(req_valid), .ch_req_ready(req_ready), .ch_req_write(req_write),
        .ch_req_address(req_address), .ch_req_wdata(req_wdata), .ch_req_byte_enable(req_be),
        .ch_resp_valid(resp_valid), .ch_resp_rdata(resp_rdata),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_write(mem_write),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_byte_enable(mem_be),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
    );

    bus_arbiter_rr #(.CHANNELS(4), .ADDRESS_WIDTH(32), .DATA_WIDTH(32)) u_dut4 (
        .clock(clock), .reset(reset),
        .ch_req_valid(req_valid4), .ch_req_ready(req_ready4), .ch_req_write(req_write4),
        .ch_req_address(req_address4), .ch_req_wdata(req_wdata4), .ch_req_byte_enable(req_be4),
        .ch_resp_valid(resp_valid4), .ch_resp_rdata(resp_rdata4),
        .mem_valid(mem_valid4), .mem_ready(mem_ready4), .mem_write(mem_write4),
        .mem_address(mem_address4), .mem_wdata(mem_wdata4), .mem_byte_enable(mem_be4),
        .mem_resp_valid(mem_resp_valid4), .mem_rdata(mem_rdata4)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        #1;
        check("rst_ready",   64'(req_ready),  64'h0);
        check("rst_resp",    64'(resp_valid), 64'h0);
        check("rst_rdata",   64'(resp_rdata), 64'h0);
        check("rst_mvalid",  64'(mem_valid),  64'h0);
        check("rst_mwrite",  64'(mem_write),  64'h0);
        check("rst_maddr",   64'(mem_address), 64'h0);

        // Single read on ch0, zero wait states
        req_address[31:0] = 32'h0000_1000;
        req_valid = 2'b01;
        #1;
        check("rd_ready", 64'(req_ready), 64'h1);
        tick();
        req_valid = 2'b00;
        mem_ready = 1'b1;
        mem_resp_valid = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        #1;
        check("rd_mvalid", 64'(mem_valid),   64'h1);
        check("rd_maddr",  64'(mem_address), 64'h1000);
        check("rd_mwrite", 64'(mem_write),   64'h0);
        check("rd_ready_busy", 64'(req_ready), 64'h0);
        tick();
        mem_ready = 1'b0;
        mem_resp_valid = 1'b0;
        #1;
        check("rd_mvalid_drop", 64'(mem_valid),  64'h0);
        check("rd_resp",        64'(resp_valid), 64'h1);
        check("rd_rdata",       64'(resp_rdata), 64'hDEAD_BEEF);
        tick();
        check("rd_resp_pulse", 64'(resp_valid), 64'h0);
        check("rd_rdata_hold", 64'(resp_rdata), 64'hDEAD_BEEF);

        // Both channels requesting continuously from reset
        do_reset();
        req_address[31:0]  = 32'h100;
        req_address[63:32] = 32'h200;
        req_valid = 2'b11;
        mem_ready = 1'b1;
        mem_resp_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            mem_rdata = 32'hA0 + 32'(k);
            #1;
            check("rr_ready", 64'(req_ready), (k % 2 == 0) ? 64'h1 : 64'h2);
            tick();
            check("rr_maddr", 64'(mem_address), (k % 2 == 0) ? 64'h100 : 64'h200);
            tick();
            check("rr_resp",  64'(resp_valid), (k % 2 == 0) ? 64'h1 : 64'h2);
            check("rr_rdata", 64'(resp_rdata), 64'hA0 + 64'(k));
            tick();
        end
        req_valid = 2'b00;
        mem_ready = 1'b0;
        mem_resp_valid = 1'b0;

        // Wait states: 3 stalled ISSUE cycles, then accept, response 2 cycles later
        req_address[31:0] = 32'h2000;
        req_valid = 2'b01;
        #1;
        check("ws_ready", 64'(req_ready), 64'h1);
        tick();
        req_valid = 2'b11;
        req_address[31:0] = 32'hFFFF_0000;
        for (int j = 0; j < 3; j++) begin
            #1;
            check("ws_mvalid", 64'(mem_valid),   64'h1);
            check("ws_maddr",  64'(mem_address), 64'h2000);
            check("ws_ready0", 64'(req_ready),   64'h0);
            tick();
        end
        mem_ready = 1'b1;
        #1;
        check("ws_mvalid4", 64'(mem_valid),   64'h1);
        check("ws_maddr4",  64'(mem_address), 64'h2000);
        tick();
        mem_ready = 1'b0;
        #1;
        check("ws_wait_mvalid", 64'(mem_valid),  64'h0);
        check("ws_wait_ready",  64'(req_ready),  64'h0);
        check("ws_wait_resp",   64'(resp_valid), 64'h0);
        tick();
        check("ws_wait2_resp", 64'(resp_valid), 64'h0);
        mem_resp_valid = 1'b1;
        mem_rdata = 32'h1234_5678;
        tick();
        mem_resp_valid = 1'b0;
        req_valid = 2'b00;
        #1;
        check("ws_resp",  64'(resp_valid), 64'h1);
        check("ws_rdata", 64'(resp_rdata), 64'h1234_5678);
        tick();
        check("ws_resp_pulse", 64'(resp_valid), 64'h0);

        // Write on ch1
        req_write = 2'b10;
        req_address[63:32] = 32'h20;
        req_wdata[63:32] = 32'h0000_55AA;
        req_be[7:4] = 4'b0011;
        req_valid = 2'b10;
        #1;
        check("wr_ready", 64'(req_ready), 64'h2);
        tick();
        req_valid = 2'b00;
        mem_ready = 1'b1;
        mem_resp_valid = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        #1;
        check("wr_mvalid", 64'(mem_valid),   64'h1);
        check("wr_mwrite", 64'(mem_write),   64'h1);
        check("wr_maddr",  64'(mem_address), 64'h20);
        check("wr_wdata",  64'(mem_wdata),   64'h55AA);
        check("wr_be",     64'(mem_be),      64'h3);
        tick();
        mem_ready = 1'b0;
        mem_resp_valid = 1'b0;
        check("wr_resp",  64'(resp_valid), 64'h2);
        check("wr_rdata", 64'(resp_rdata), 64'h0);
        tick();

        // Reset during WAIT aborts the transaction
        req_write = 2'b00;
        req_address[63:32] = 32'h30;
        req_valid = 2'b10;
        #1;
        check("ab_ready", 64'(req_ready), 64'h2);
        tick();
        req_valid = 2'b00;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        check("ab_wait_mvalid", 64'(mem_valid), 64'h0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("ab_maddr",  64'(mem_address), 64'h0);
        check("ab_wdata",  64'(mem_wdata),   64'h0);
        check("ab_be",     64'(mem_be),      64'h0);
        check("ab_mvalid", 64'(mem_valid),   64'h0);
        check("ab_mwrite", 64'(mem_write),   64'h0);
        mem_resp_valid = 1'b1;
        mem_rdata = 32'h0000_0BAD;
        tick();
        mem_resp_valid = 1'b0;
        check("ab_no_resp",  64'(resp_valid), 64'h0);
        check("ab_rdata",    64'(resp_rdata), 64'h0);
        tick();
        check("ab_no_resp2", 64'(resp_valid), 64'h0);
        req_valid = 2'b11;
        #1;
        check("ab_first_ch0", 64'(req_ready), 64'h1);
        req_valid = 2'b00;

        // Four channels: pointer starts at ch3, spurious response in IDLE ignored
        do_reset();
        mem_resp_valid4 = 1'b1;
        mem_rdata4 = 32'h77;
        tick();
        mem_resp_valid4 = 1'b0;
        check("c4_spur_resp",   64'(resp_valid4), 64'h0);
        check("c4_spur_rdata",  64'(resp_rdata4), 64'h0);
        check("c4_spur_mvalid", 64'(mem_valid4),  64'h0);
        req_address4[95:64]  = 32'h2200;
        req_address4[127:96] = 32'h3300;
        req_wdata4[95:64]    = 32'h2222;
        req_be4[11:8]        = 4'hF;
        req_valid4 = 4'b1100;
        mem_ready4 = 1'b1;
        mem_resp_valid4 = 1'b1;
        #1;
        check("c4_ready_ch2", 64'(req_ready4), 64'h4);
        tick();
        check("c4_maddr_ch2", 64'(mem_address4), 64'h2200);
        check("c4_wdata_ch2", 64'(mem_wdata4),   64'h2222);
        check("c4_be_ch2",    64'(mem_be4),      64'hF);
        check("c4_mwrite",    64'(mem_write4),   64'h0);
        tick();
        check("c4_resp_ch2", 64'(resp_valid4), 64'h4);
        check("c4_rdata",    64'(resp_rdata4), 64'h77);
        tick();
        check("c4_ready_ch3", 64'(req_ready4), 64'h8);
        tick();
        check("c4_maddr_ch3", 64'(mem_address4), 64'h3300);
        tick();
        check("c4_resp_ch3", 64'(resp_valid4), 64'h8);
        req_valid4 = 4'b0000;
        mem_ready4 = 1'b0;
        mem_resp_valid4 = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
